// File: rtl/lightwave_pkg.sv
// lightWave shared types and constants for the button input path.
// Holds debounce FSM state encodings and the 100 MHz default interval.
package lightwave_pkg;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    typedef enum logic [1:0] {
        DB_ZERO  = 2'b00,
        DB_WAIT1 = 2'b01,
        DB_ONE   = 2'b10,
        DB_WAIT0 = 2'b11
    } db_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Flop chain of configurable depth, cleared by synchronous reset.
// Used as a metastability synchroniser on lightWave input pins.
module sync_2ff #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/debounce.sv
// Push-button debouncer: synchroniser plus 4-state stability-timing FSM.
// Define DEBOUNCE_SYNC_EN for a two-flop synchroniser (else one flop).
module debounce
    import lightwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic noisy_in,
    output logic db_out,
    output logic busy
);

`ifdef DEBOUNCE_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 1;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    db_state_t        state;
    logic [CNT_W-1:0] count;

    sync_2ff #(
        .DEPTH (SYNC_DEPTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (noisy_in),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DB_ZERO;
            count <= '0;
        end else begin
            case (state)
                DB_ZERO: begin
                    if (s) begin
                        state <= DB_WAIT1;
                        count <= '0;
                    end
                end
                DB_WAIT1: begin
                    if (!s) begin
                        state <= DB_ZERO;
                    end else if (count == CNT_MAX) begin
                        state <= DB_ONE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DB_ONE: begin
                    if (!s) begin
                        state <= DB_WAIT0;
                        count <= '0;
                    end
                end
                DB_WAIT0: begin
                    if (s) begin
                        state <= DB_ONE;
                    end else if (count == CNT_MAX) begin
                        state <= DB_ZERO;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= DB_ZERO;
                end
            endcase
        end
    end

    // Moore outputs: the level holds its old value while a change is timed
    assign db_out = (state == DB_ONE) || (state == DB_WAIT0);
    assign busy   = (state == DB_WAIT1) || (state == DB_WAIT0);

endmodule
